// File: rtl/cordic_const_sequencer.sv
// Multi-mode CORDIC constant store (circular/linear/hyperbolic, binary32) with a built-in
// iteration sequencer. Define CORDIC_REPEAT_EN to repeat hyperbolic indices 4, 13 and 40.
module cordic_const_sequencer #(
  parameter int unsigned P = 32,
  parameter int unsigned D = 5
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  input  logic [1:0]   MODE,
  input  logic [D:0]   NITER,
  input  logic         ADV,
  output logic [P-1:0] O_D,
  output logic [D-1:0] ITER,
  output logic         VALID,
  output logic         BUSY,
  output logic         DONE,
  output logic         ERR
);

  localparam logic [1:0] ModeCirc = 2'b00;
  localparam logic [1:0] ModeHyp  = 2'b10;
  localparam logic [1:0] ModeBad  = 2'b11;

  typedef enum logic [1:0] {StIdle, StFetch, StHold, StFin} state_e;

  state_e     state_q;
  logic [1:0] mode_q;
  logic [D:0] niter_q;
  logic [D:0] cnt_q;
  logic [D:0] cnt_next;
  logic [D-1:0] s_q;
  logic       repeat_now;

  assign cnt_next = cnt_q + 1'b1;

  // 2^-s in binary32; also exact for atan/atanh once s >= 12 (x^3/3 below half an ulp).
  function automatic logic [31:0] pow2_word(input int s);
    if (s > 126) return 32'h0;
    return {1'b0, 8'(127 - s), 23'h0};
  endfunction

  function automatic logic [31:0] rom_word(input logic [1:0] m, input int s);
    logic [31:0] w;
    w = pow2_word(s);
    if (m == ModeCirc) begin
      case (s)
        0:  w = 32'h3F490FDB;
        1:  w = 32'h3EED6338;
        2:  w = 32'h3E7ADBB0;
        3:  w = 32'h3DFEADD5;
        4:  w = 32'h3D7FAADE;
        5:  w = 32'h3CFFEAAE;
        6:  w = 32'h3C7FFAAB;
        7:  w = 32'h3BFFFEAB;
        8:  w = 32'h3B7FFFAB;
        9:  w = 32'h3AFFFFEB;
        10: w = 32'h3A7FFFFB;
        11: w = 32'h39FFFFFF;
        default: ;
      endcase
    end else if (m == ModeHyp) begin
      // Index 0 (atanh 1) is never addressed; stored as +inf.
      case (s)
        0:  w = 32'h7F800000;
        1:  w = 32'h3F0C9F54;
        2:  w = 32'h3E82C578;
        3:  w = 32'h3E00AC49;
        4:  w = 32'h3D802AC4;
        5:  w = 32'h3D000AAC;
        6:  w = 32'h3C8002AB;
        7:  w = 32'h3C0000AB;
        8:  w = 32'h3B80002B;
        9:  w = 32'h3B00000B;
        10: w = 32'h3A800003;
        11: w = 32'h3A000001;
        default: ;
      endcase
    end
    return w;
  endfunction

`ifdef CORDIC_REPEAT_EN
  logic rep_q;

  assign repeat_now = (mode_q == ModeHyp) && !rep_q &&
                      ((int'(s_q) == 4) || (int'(s_q) == 13) || (int'(s_q) == 40));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rep_q <= 1'b0;
    end else if (state_q == StIdle) begin
      rep_q <= 1'b0;
    end else if (state_q == StHold && ADV) begin
      rep_q <= repeat_now;
    end
  end
`else
  assign repeat_now = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      mode_q  <= '0;
      niter_q <= '0;
      cnt_q   <= '0;
      s_q     <= '0;
      O_D     <= '0;
      ITER    <= '0;
      VALID   <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      ERR     <= 1'b0;
    end else begin
      DONE <= 1'b0;
      ERR  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (START) begin
            mode_q  <= MODE;
            niter_q <= NITER;
            cnt_q   <= '0;
            s_q     <= (MODE == ModeHyp) ? D'(1) : '0;
            BUSY    <= 1'b1;
            if (NITER == '0 || MODE == ModeBad) begin
              state_q <= StFin;
              DONE    <= 1'b1;
              ERR     <= (MODE == ModeBad);
            end else begin
              state_q <= StFetch;
            end
          end
        end
        StFetch: begin
          O_D     <= P'(rom_word(mode_q, int'(s_q)));
          ITER    <= s_q;
          VALID   <= 1'b1;
          state_q <= StHold;
        end
        StHold: begin
          if (ADV) begin
            VALID <= 1'b0;
            O_D   <= '0;
            ITER  <= '0;
            cnt_q <= cnt_next;
            if (cnt_next == niter_q) begin
              state_q <= StFin;
              DONE    <= 1'b1;
            end else if (repeat_now) begin
              state_q <= StFetch;
            end else if (s_q == '1) begin
              // Table exhausted with entries still owed: stop rather than wrap.
              state_q <= StFin;
              DONE    <= 1'b1;
              ERR     <= 1'b1;
            end else begin
              s_q     <= s_q + 1'b1;
              state_q <= StFetch;
            end
          end
        end
        StFin: begin
          state_q <= StIdle;
          BUSY    <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_const_sequencer.sv
// Scoreboard bench for cordic_const_sequencer: expected entries are queued at launch and
// popped as each new VALID entry appears.
module tb_cordic_const_sequencer;
  localparam int unsigned P = 32;
  localparam int unsigned D = 5;

  logic         CLK = 1'b0;
  logic         RST;
  logic         START;
  logic [1:0]   MODE;
  logic [D:0]   NITER;
  logic         ADV;
  logic [P-1:0] O_D;
  logic [D-1:0] ITER;
  logic         VALID;
  logic         BUSY;
  logic         DONE;
  logic         ERR;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [D-1:0] iter;
    logic [P-1:0] od;
    logic         chk_od;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         mon_e;
  logic [P-1:0] cur_od;
  logic         cur_chk = 1'b0;
  logic         prev_valid = 1'b0;
  int           first_valid_c;
  logic [31:0]  circ3 [3] = '{32'h3F490FDB, 32'h3EED6338, 32'h3E7ADBB0};

  always #5 CLK = ~CLK;

  cordic_const_sequencer #(.P(P), .D(D)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .MODE  (MODE),
    .NITER (NITER),
    .ADV   (ADV),
    .O_D   (O_D),
    .ITER  (ITER),
    .VALID (VALID),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .ERR   (ERR)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int s, input logic [31:0] od, input logic chk);
    exp_t e;
    e.iter   = D'(s);
    e.od     = P'(od);
    e.chk_od = chk;
    exp_q.push_back(e);
  endtask

  // Scoreboard: each rising VALID must match the next queued entry.
  always @(negedge CLK) begin
    if (!RST && VALID && !prev_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", 64'(VALID), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("iter", 64'(ITER), 64'(mon_e.iter));
        if (mon_e.chk_od) check("od", 64'(O_D), 64'(mon_e.od));
        cur_od  = mon_e.od;
        cur_chk = mon_e.chk_od;
      end
    end
    prev_valid = VALID;
  end

  task automatic start_run(input logic [1:0] m, input logic [D:0] n);
    @(posedge CLK); #1;
    START = 1'b1;
    MODE  = m;
    NITER = n;
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  // direct: DONE expected straight from IDLE with no entries emitted.
  task automatic run(input logic [1:0] m, input logic [D:0] n, input int hold,
                     input logic exp_err, input logic direct, input logic poke_start);
    int held      = 0;
    int since_adv = 100;
    bit seen      = 1'b0;
    bit got_valid = 1'b0;
    start_run(m, n);
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge CLK);
      START = 1'b0;
      since_adv++;
      if (DONE) begin
        seen = 1'b1;
        ADV  = 1'b0;
        check("err", 64'(ERR), 64'(exp_err));
        if (direct) check("done_first", 64'(c), 64'd0);
        else        check("done_lat", 64'(since_adv), 64'd1);
      end else if (VALID) begin
        if (!got_valid) begin
          got_valid = 1'b1;
          check("start_lat", 64'(c), 64'd1);
        end
        check("busy", 64'(BUSY), 64'd1);
        if (held > 0 && cur_chk) check("hold_od", 64'(O_D), 64'(cur_od));
        if (poke_start && held == 3) START = 1'b1;
        if (held == hold) begin
          ADV       = 1'b1;
          since_adv = 0;
        end else begin
          ADV = 1'b0;
        end
        held++;
      end else begin
        ADV  = 1'b0;
        held = 0;
        check("od_zero", 64'(O_D), 64'd0);
      end
    end
    ADV = 1'b0;
    if (!seen) check("timeout", 64'(DONE), 64'd1);
    check("queue_left", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    @(negedge CLK);
    check("done_pulse", 64'(DONE), 64'd0);
    check("busy_after", 64'(BUSY), 64'd0);
  endtask

  initial begin
    RST   = 1'b1;
    START = 1'b0;
    ADV   = 1'b0;
    MODE  = 2'b00;
    NITER = '0;
    @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    check("rst_valid", 64'(VALID), 64'd0);
    check("rst_busy", 64'(BUSY), 64'd0);
    check("rst_done", 64'({DONE, ERR}), 64'd0);
    check("rst_od", 64'(O_D), 64'd0);
    START = 1'b0;
    RST   = 1'b0;

    // Reset in the middle of HOLD.
    for (int s = 0; s < 3; s++) push(s, circ3[s], 1'b1);
    start_run(2'b00, 3);
    for (int c = 0; c < 10 && !VALID; c++) @(negedge CLK);
    check("pre_rst_valid", 64'(VALID), 64'd1);
    #2 RST = 1'b1;
    #1;
    check("mid_rst_valid", 64'(VALID), 64'd0);
    check("mid_rst_busy", 64'(BUSY), 64'd0);
    check("mid_rst_od", 64'(O_D), 64'd0);
    exp_q.delete();
    @(negedge CLK);
    RST = 1'b0;

    // Circular, ADV right after each VALID.
    for (int s = 0; s < 3; s++) push(s, circ3[s], 1'b1);
    run(2'b00, 3, 0, 1'b0, 1'b0, 1'b0);

    // Hyperbolic, six entries.
`ifdef CORDIC_REPEAT_EN
    push(1, 32'h3F0C9F54, 1'b1);
    push(2, 0, 1'b0);
    push(3, 0, 1'b0);
    push(4, 0, 1'b0);
    push(4, 0, 1'b0);
    push(5, 0, 1'b0);
`else
    push(1, 32'h3F0C9F54, 1'b1);
    for (int s = 2; s <= 6; s++) push(s, 0, 1'b0);
`endif
    run(2'b10, 6, 1, 1'b0, 1'b0, 1'b0);

    // Linear, ADV withheld for 10 cycles, START poked mid-run.
    push(0, 32'h3F800000, 1'b1);
    push(1, 32'h3F000000, 1'b1);
    run(2'b01, 2, 10, 1'b0, 1'b0, 1'b1);

    // Illegal mode, then zero-length run.
    run(2'b11, 4, 0, 1'b1, 1'b1, 1'b0);
    run(2'b00, 0, 0, 1'b0, 1'b1, 1'b0);

    // Circular overflow: table ends at index 31 with entries still owed.
    for (int s = 0; s < 32; s++) begin
      if (s < 3)        push(s, circ3[s], 1'b1);
      else if (s >= 13) push(s, {1'b0, 8'(127 - s), 23'h0}, 1'b1);
      else              push(s, 0, 1'b0);
    end
    run(2'b00, 40, 0, 1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
